midi_tx_sched: RTL

Message-level scheduler that shares the single MIDI UART transmitter (driving the MIDI OUT pad, `mprj_io[15]`) between several byte producers: the USB-MIDI bridge, the CPU Wishbone TX FIFO and the MIDI-thru path. It grants the transmitter round-robin, holds the grant until a complete MIDI message (marked by `last`) has been accepted, so messages are never interleaved on the wire, and it reclaims the transmitter from a requester that stalls mid-message. It sits in `pyfive_top` between the producers and `midi_uart_tx`.

---
 rtl/midi_tx_sched_pkg.sv | 20 ++
 rtl/midi_tx_sched_if.sv | 23 ++
 rtl/midi_rr_pick.sv | 34 +++
 rtl/midi_tx_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/midi_tx_sched_pkg.sv
// Shared types for the MIDI transmit scheduler: requester index type,
// FSM state encoding and the stall-counter width helper.
package midi_tx_sched_pkg;

    // Wide enough to name up to eight requesters.
    localparam int ID_W = 3;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } sched_state_e;

    // Width of the stall counter; a disabled timeout still needs one bit.
    function automatic int stall_cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/midi_tx_sched_if.sv
// Producer byte streams plus the UART-side handshake of the scheduler.
// The scheduler uses the slave view; the producers/UART side uses master.
interface midi_tx_sched_if #(
    parameter int N_REQ = 3
);
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport slave (
        input  req_data, req_last, req_valid, tx_ready,
        output req_ready, tx_data, tx_valid
    );

    modport master (
        output req_data, req_last, req_valid, tx_ready,
        input  req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/midi_rr_pick.sv
// Combinational N-way round-robin picker: returns the first set request
// searching upward (with wrap) from last_id_i + 1.
module midi_rr_pick
    import midi_tx_sched_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req_i,
    input  req_id_t          last_id_i,
    output req_id_t          id_o,
    output logic             any_o
);

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        int               idx;
        logic [N_REQ-1:0] sel;
        id_o  = '0;
        any_o = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_id_i) + k) % N_REQ;
            sel = N_REQ'(1) << idx;
            if (|(req_i & sel)) begin
                id_o  = ID_W'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_tx_sched.sv
// Message-level scheduler sharing one MIDI UART transmitter between
// several byte producers. A grant is held until the byte flagged 'last'
// is accepted, and is revoked if the owner stops presenting bytes for
// TIMEOUT cycles (TIMEOUT = 0 disables revocation).
module midi_tx_sched
    import midi_tx_sched_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    midi_tx_sched_if.slave        bus,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  busy_o,
    output logic                  err_stb_o,
    output logic [ID_W-1:0]       err_id_o
);

    localparam int               CNT_W     = stall_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    sched_state_e     state_q, state_d;
    req_id_t          gnt_id_q, gnt_id_d;
    req_id_t          last_id_q, last_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_stb_q, err_stb_d;
    req_id_t          err_id_q, err_id_d;

    logic [N_REQ-1:0] sel_vec;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             handshake;
    req_id_t          pick_id;
    logic             pick_any;

    midi_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i     (bus.req_valid),
        .last_id_i (last_id_q),
        .id_o      (pick_id),
        .any_o     (pick_any)
    );

    // Isolate the current owner's lane.
    assign sel_vec   = N_REQ'(1) << gnt_id_q;
    assign sel_valid = |(bus.req_valid & sel_vec);
    assign sel_last  = |(bus.req_last & sel_vec);
    assign handshake = (state_q == ST_LOCK) && sel_valid && bus.tx_ready;

    // Byte mux: OR of the one selected lane.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_vec[i]) begin
                sel_data = sel_data | bus.req_data[8*i +: 8];
            end
        end
    end

    // Combinational passthrough of the owner's stream while locked.
    always_comb begin
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        bus.req_ready = '0;
        grant_o       = '0;
        if (state_q == ST_LOCK) begin
            grant_o       = sel_vec;
            bus.tx_data   = sel_data;
            bus.tx_valid  = sel_valid;
            bus.req_ready = bus.tx_ready ? sel_vec : '0;
        end
    end

    assign busy_o    = (state_q == ST_LOCK);
    assign err_stb_o = err_stb_q;
    assign err_id_o  = err_id_q;

    // Next-state: arbitration, message lock, stall counting and revocation.
    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        err_stb_d = 1'b0;
        err_id_d  = err_id_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    gnt_id_d = pick_id;
                    state_d  = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (handshake) begin
                    cnt_d = '0;
                    if (sel_last) begin
                        state_d   = ST_IDLE;
                        last_id_d = gnt_id_q;
                    end
                end else if (!sel_valid && (TIMEOUT != 0)) begin
                    // Backpressure (valid high, ready low) never reaches here.
                    if (cnt_q == CNT_LIMIT) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        err_stb_d = 1'b1;
                        err_id_d  = gnt_id_q;
                        last_id_d = gnt_id_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_id_q  <= '0;
            last_id_q <= ID_W'(N_REQ - 1);
            cnt_q     <= '0;
            err_stb_q <= 1'b0;
            err_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            err_stb_q <= err_stb_d;
            err_id_q  <= err_id_d;
        end
    end

endmodule
